key_code_encoder: RTL and testbench

Parametrised successor to the transmitter's push-button encoder. It takes NUM_KEYS active-low keys and synchronises and debounces them. It selects the lowest-index pressed key and emits that key's pulse-train code once per press through a valid/ready handshake to the downstream serialiser. Optional auto-repeat re-emits the code while the key stays held.

---
 rtl/key_code_if.sv | 25 ++
 rtl/key_code_encoder.sv | 165 ++++++++++++++++
 tb/tb_key_code_encoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_code_if.sv
// Valid/ready channel that carries a key's pulse-train code and the key's index
// from the encoder to the downstream serialiser.
interface key_code_if #(
  parameter int CODE_W = 8,
  parameter int IDX_W  = 2
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic [IDX_W-1:0]  key_idx;

  modport master (
    output code_valid,
    output code,
    output key_idx,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    input  key_idx,
    output code_ready
  );
endinterface

// File: rtl/key_code_encoder.sv
// Debounced priority key encoder: emits the lowest-index pressed key's pulse-train
// code once per press over a valid/ready channel, with optional auto-repeat.
module key_code_encoder #(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] KEY,
  key_code_if.master          bus
);

  localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  if (NUM_KEYS < 1) begin : g_chk_keys
    $error("key_code_encoder: NUM_KEYS must be >= 1");
  end
  if (CODE_W < 2 * NUM_KEYS - 1) begin : g_chk_code_w
    $error("key_code_encoder: CODE_W must be >= 2*NUM_KEYS-1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("key_code_encoder: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 0) begin : g_chk_repeat
    $error("key_code_encoder: REPEAT_CYCLES must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    SEND     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Key k sets every other bit from the MSB down, k+1 pulses in total.
  function automatic logic [CODE_W-1:0] code_for(input logic [IDX_W-1:0] k);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (IDX_W'(j) <= k) c[CODE_W-1-2*j] = 1'b1;
    end
    return c;
  endfunction

  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] pressed;
  logic [IDX_W-1:0]    win;
  logic                any_pressed;
  logic                higher_pressed;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   rcnt, rcnt_n;
  logic [HCNT_W-1:0]  hcnt, hcnt_n;

  // NOTE: clocked state always uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1 <= '1;
      ks     <= '1;
    end else begin
      key_s1 <= KEY;
      ks     <= key_s1;
    end
  end

  assign pressed     = ~ks;
  assign any_pressed = |pressed;

  // Scan from the top down so the lowest pressed index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) win = IDX_W'(i);
    end
  end

  assign higher_pressed = any_pressed && (win < idx);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (any_pressed) begin
          idx_n   = win;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (higher_pressed) begin
          idx_n = win;
          cnt_n = '0;
        end else if (!pressed[idx]) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = SEND;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        // Once here the code is committed; only the handshake moves us on.
        if (bus.code_valid && bus.code_ready) begin
          state_n = HOLD;
          rcnt_n  = '0;
          hcnt_n  = '0;
        end
      end
      HOLD: begin
        if (!pressed[idx]) begin
          hcnt_n = '0;
          if (rcnt == CNT_LAST) state_n = IDLE;
          else                  rcnt_n  = rcnt + 1'b1;
        end else begin
          rcnt_n = '0;
          if (REPEAT_CYCLES > 0) begin
            if (hcnt == HCNT_LAST) state_n = SEND;
            else                   hcnt_n  = hcnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with SEND exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      rcnt           <= '0;
      hcnt           <= '0;
      bus.code_valid <= 1'b0;
      bus.code       <= '0;
      bus.key_idx    <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      cnt            <= cnt_n;
      rcnt           <= rcnt_n;
      hcnt           <= hcnt_n;
      bus.code_valid <= (state_n == SEND);
      bus.code       <= (state_n == SEND) ? code_for(idx_n) : '0;
      bus.key_idx    <= (state_n == SEND) ? idx_n : '0;
    end
  end

endmodule

// File: tb/tb_key_code_encoder.sv
// Directed bench for key_code_encoder: one DUT without auto-repeat, one with a
// repeat interval of 8, both with a 4-cycle debounce.
module tb_key_code_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] key_a;
  logic [3:0] key_b;
  int         errors;
  int         checks;

  key_code_if #(.CODE_W(8), .IDX_W(2)) bus_a ();
  key_code_if #(.CODE_W(8), .IDX_W(2)) bus_b ();

  key_code_encoder #(
    .NUM_KEYS(4), .CODE_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .KEY(key_a), .bus(bus_a)
  );

  key_code_encoder #(
    .NUM_KEYS(4), .CODE_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
  ) dut_rep (
    .clk(clk), .rst(rst), .KEY(key_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    key_a = 4'b1111;
    key_b = 4'b1111;
    bus_a.code_ready = 1'b1;
    bus_b.code_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_a.code_valid !== 1'b0 || bus_a.code !== 8'h00 || bus_a.key_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_a: valid=%b code=%b idx=%0d expected 0/00000000/0",
               bus_a.code_valid, bus_a.code, bus_a.key_idx);
    end
    checks++;
    if (bus_b.code_valid !== 1'b0 || bus_b.code !== 8'h00 || bus_b.key_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_b: valid=%b code=%b idx=%0d expected 0/00000000/0",
               bus_b.code_valid, bus_b.code, bus_b.key_idx);
    end
  endtask

  // Release everything and confirm nothing is emitted while the release debounces.
  task automatic test_release(input string name);
    key_a = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (bus_a.code_valid !== 1'b0 || bus_a.code !== 8'h00) begin
        errors++;
        $display("FAIL %s release edge %0d: valid=%b code=%b expected 0/00000000",
                 name, e, bus_a.code_valid, bus_a.code);
      end
    end
  endtask

  task automatic test_single_press();
    key_a = 4'b1011;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      checks++;
      if (e == 7) begin
        if (bus_a.code_valid !== 1'b1 || bus_a.code !== 8'b10101000 || bus_a.key_idx !== 2'd2) begin
          errors++;
          $display("FAIL single_press edge %0d: valid=%b code=%b idx=%0d expected 1/10101000/2",
                   e, bus_a.code_valid, bus_a.code, bus_a.key_idx);
        end
      end else if (bus_a.code_valid !== 1'b0 || bus_a.code !== 8'h00) begin
        errors++;
        $display("FAIL single_press edge %0d: valid=%b code=%b expected 0/00000000",
                 e, bus_a.code_valid, bus_a.code);
      end
    end
    test_release("single_press");
  endtask

  task automatic test_bounce();
    key_a = 4'b1101;
    repeat (3) @(negedge clk);
    key_a = 4'b1111;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      checks++;
      if (bus_a.code_valid !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d: valid=%b expected 0", e, bus_a.code_valid);
      end
    end
  endtask

  task automatic test_priority();
    int valid_cnt;
    valid_cnt = 0;
    key_a = 4'b0110;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (bus_a.code_valid === 1'b1) begin
        valid_cnt++;
        checks++;
        if (e != 7 || bus_a.code !== 8'b10000000 || bus_a.key_idx !== 2'd0) begin
          errors++;
          $display("FAIL priority edge %0d: code=%b idx=%0d expected edge 7 10000000/0",
                   e, bus_a.code, bus_a.key_idx);
        end
      end
    end
    checks++;
    if (valid_cnt != 1) begin
      errors++;
      $display("FAIL priority_count: got %0d emissions expected 1", valid_cnt);
    end
    test_release("priority");
    key_a = 4'b0111;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      checks++;
      if (e == 7) begin
        if (bus_a.code_valid !== 1'b1 || bus_a.code !== 8'b10101010 || bus_a.key_idx !== 2'd3) begin
          errors++;
          $display("FAIL key3 edge %0d: valid=%b code=%b idx=%0d expected 1/10101010/3",
                   e, bus_a.code_valid, bus_a.code, bus_a.key_idx);
        end
      end else if (bus_a.code_valid !== 1'b0) begin
        errors++;
        $display("FAIL key3 edge %0d: valid=%b expected 0", e, bus_a.code_valid);
      end
    end
    test_release("key3");
  endtask

  task automatic test_backpressure();
    bus_a.code_ready = 1'b0;
    key_a = 4'b1101;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (bus_a.code_valid !== 1'b0) begin
        errors++;
        $display("FAIL backpressure pre edge %0d: valid=%b expected 0", e, bus_a.code_valid);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus_a.code_valid !== 1'b1 || bus_a.code !== 8'b10100000 || bus_a.key_idx !== 2'd1) begin
        errors++;
        $display("FAIL backpressure hold %0d: valid=%b code=%b idx=%0d expected 1/10100000/1",
                 c, bus_a.code_valid, bus_a.code, bus_a.key_idx);
      end
    end
    bus_a.code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.code_valid !== 1'b0 || bus_a.code !== 8'h00 || bus_a.key_idx !== 2'd0) begin
      errors++;
      $display("FAIL backpressure handshake: valid=%b code=%b idx=%0d expected 0/00000000/0",
               bus_a.code_valid, bus_a.code, bus_a.key_idx);
    end
    test_release("backpressure");
  endtask

  task automatic test_auto_repeat();
    bit exp_valid;
    key_b = 4'b1110;
    for (int e = 1; e <= 55; e++) begin
      @(negedge clk);
      if (e == 40) key_b = 4'b1111;
      exp_valid = (e == 7) || (e == 16) || (e == 25) || (e == 34);
      checks++;
      if (bus_b.code_valid !== exp_valid ||
          bus_b.code !== (exp_valid ? 8'b10000000 : 8'h00)) begin
        errors++;
        $display("FAIL auto_repeat edge %0d: valid=%b code=%b expected valid=%b",
                 e, bus_b.code_valid, bus_b.code, exp_valid);
      end
    end
  endtask

  task automatic test_reset_in_send();
    bus_a.code_ready = 1'b0;
    key_a = 4'b1011;
    repeat (7) @(negedge clk);
    checks++;
    if (bus_a.code_valid !== 1'b1 || bus_a.code !== 8'b10101000) begin
      errors++;
      $display("FAIL rst_send pre: valid=%b code=%b expected 1/10101000",
               bus_a.code_valid, bus_a.code);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_a.code_valid !== 1'b0 || bus_a.code !== 8'h00 || bus_a.key_idx !== 2'd0) begin
      errors++;
      $display("FAIL rst_send drop: valid=%b code=%b idx=%0d expected 0/00000000/0",
               bus_a.code_valid, bus_a.code, bus_a.key_idx);
    end
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      checks++;
      if (e == 7) begin
        if (bus_a.code_valid !== 1'b1 || bus_a.code !== 8'b10101000 || bus_a.key_idx !== 2'd2) begin
          errors++;
          $display("FAIL rst_send refire edge %0d: valid=%b code=%b idx=%0d expected 1/10101000/2",
                   e, bus_a.code_valid, bus_a.code, bus_a.key_idx);
        end
      end else if (bus_a.code_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_send refire edge %0d: valid=%b expected 0", e, bus_a.code_valid);
      end
    end
    bus_a.code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_send handshake: valid=%b expected 0", bus_a.code_valid);
    end
    test_release("rst_send");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_priority();
    test_backpressure();
    test_auto_repeat();
    test_reset_in_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
